// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_pkg : shared FSM encodings, defaults and region decode helper      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package wb_pkg;

  localparam int unsigned c_MAX_NS = 16;
  localparam int unsigned c_MAX_DB = 8;

  localparam logic [31:0] c_UNMAPPED_DATA = 32'hDEADBEEF;

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_ACTIVE = 2'd1;
  localparam logic [1:0] c_ST_RESP   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = c_ST_IDLE,
    ST_ACTIVE = c_ST_ACTIVE,
    ST_RESP   = c_ST_RESP
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } dec_t;

  // Descending scan so the lowest matching slave index is the one that sticks.
  function automatic dec_t decode_region(
    input logic [c_MAX_NS*c_MAX_DB-1:0] map,
    input int unsigned                  ns,
    input int unsigned                  db,
    input logic [c_MAX_DB-1:0]          code
  );
    dec_t                r;
    logic [c_MAX_DB-1:0] field;
    logic [c_MAX_DB-1:0] mask;
    r    = '0;
    mask = {c_MAX_DB{1'b1}} >> (c_MAX_DB - db);
    for (int i = c_MAX_NS - 1; i >= 0; i--) begin
      if (i < ns) begin
        field = c_MAX_DB'(map >> (i * db)) & mask;
        if (field == (code & mask)) begin
          r.valid = 1'b1;
          r.idx   = 4'(i);
        end
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_watchdog : per-transfer timeout counter, expires at TIMEOUT        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module wb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_disabled
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst_n, load, enable};
      assign expire   = 1'b0;
    end else begin : g_counter
      localparam int unsigned c_CW = $clog2(TIMEOUT + 1);
      logic [c_CW-1:0] r_count;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_count <= '0;
        end else if (load) begin
          r_count <= '0;
        end else if (enable && (r_count != c_CW'(TIMEOUT))) begin
          r_count <= r_count + 1'b1;
        end
      end

      assign expire = enable && (r_count == c_CW'(TIMEOUT));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_decoder : single-master Wishbone B4 classic address decoder        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module wb_decoder
  import wb_pkg::*;
#(
  parameter int unsigned      AW            = 32,
  parameter int unsigned      DW            = 32,
  parameter int unsigned      NS            = 4,
  parameter int unsigned      DB            = 4,
  parameter logic [NS*DB-1:0] SLAVE_MAP     = {4'h3, 4'h2, 4'h1, 4'h0},
  parameter bit               UNMAPPED_ERR  = 1'b1,
  parameter logic [DW-1:0]    UNMAPPED_DATA = DW'(c_UNMAPPED_DATA),
  parameter int unsigned      TIMEOUT       = 255,
  localparam int unsigned     SW            = DW / 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic [AW-1:0]    wbs_adr_i,
  input  logic [DW-1:0]    wbs_dat_i,
  output logic [DW-1:0]    wbs_dat_o,
  input  logic             wbs_we_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic [SW-1:0]    wbs_sel_i,
  output logic             wbs_ack_o,
  output logic             wbs_err_o,
  output logic [AW-1:0]    wbm_adr_o,
  output logic [DW-1:0]    wbm_dat_o,
  output logic             wbm_we_o,
  output logic [SW-1:0]    wbm_sel_o,
  output logic [NS-1:0]    wbm_cyc_o,
  output logic [NS-1:0]    wbm_stb_o,
  input  logic [NS*DW-1:0] wbm_dat_i,
  input  logic [NS-1:0]    wbm_ack_i,
  input  logic [NS-1:0]    wbm_err_i,
  output logic [7:0]       err_cnt_o
);

  localparam logic [c_MAX_NS*c_MAX_DB-1:0] c_MAP = (c_MAX_NS*c_MAX_DB)'(SLAVE_MAP);

  state_t         r_state;
  logic [AW-1:0]  r_adr;
  logic [DW-1:0]  r_wdat;
  logic           r_we;
  logic [SW-1:0]  r_sel;
  logic [3:0]     r_idx;
  logic [NS-1:0]  r_oh;
  logic [DW-1:0]  r_rdat;
  logic           r_ack;
  logic           r_err;
  logic [7:0]     r_err_cnt;

  logic [c_MAX_DB-1:0] w_code;
  dec_t                w_dec;
  logic                w_s_ack;
  logic                w_s_err;
  logic [DW-1:0]       w_s_dat;
  logic                w_expire;
  logic [7:0]          w_cnt_next;

  assign w_code     = c_MAX_DB'(wbs_adr_i[AW-1 -: DB]);
  assign w_dec      = decode_region(c_MAP, NS, DB, w_code);
  assign w_cnt_next = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

  always_comb begin
    w_s_ack = 1'b0;
    w_s_err = 1'b0;
    w_s_dat = '0;
    for (int i = 0; i < NS; i++) begin
      if (r_idx == 4'(i)) begin
        w_s_ack = wbm_ack_i[i];
        w_s_err = wbm_err_i[i];
        w_s_dat = wbm_dat_i[i*DW +: DW];
      end
    end
  end

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .load   (r_state == ST_IDLE),
    .enable (r_state == ST_ACTIVE),
    .expire (w_expire)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state   <= ST_IDLE;
      r_adr     <= '0;
      r_wdat    <= '0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_idx     <= '0;
      r_oh      <= '0;
      r_rdat    <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            r_adr  <= wbs_adr_i;
            r_wdat <= wbs_dat_i;
            r_we   <= wbs_we_i;
            r_sel  <= wbs_sel_i;
            r_idx  <= w_dec.idx;
            if (w_dec.valid) begin
              r_oh    <= NS'(1) << w_dec.idx;
              r_state <= ST_ACTIVE;
            end else begin
              r_state <= ST_RESP;
              if (UNMAPPED_ERR) begin
                r_err     <= 1'b1;
                r_err_cnt <= w_cnt_next;
              end else begin
                r_ack <= 1'b1;
                if (!wbs_we_i) r_rdat <= UNMAPPED_DATA;
              end
            end
          end
        end
        ST_ACTIVE: begin
          // Abort outranks everything; a real termination outranks the watchdog.
          if (!wbs_cyc_i) begin
            r_oh    <= '0;
            r_state <= ST_IDLE;
          end else if (w_s_err) begin
            r_oh      <= '0;
            r_err     <= 1'b1;
            r_err_cnt <= w_cnt_next;
            r_state   <= ST_RESP;
          end else if (w_s_ack) begin
            r_oh    <= '0;
            r_ack   <= 1'b1;
            if (!r_we) r_rdat <= w_s_dat;
            r_state <= ST_RESP;
          end else if (w_expire) begin
            r_oh      <= '0;
            r_err     <= 1'b1;
            r_err_cnt <= w_cnt_next;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wbs_dat_o = r_rdat;
  assign wbs_ack_o = r_ack;
  assign wbs_err_o = r_err;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_wdat;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_cyc_o = r_oh;
  assign wbm_stb_o = r_oh;
  assign err_cnt_o = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_decoder : vector table plus scoreboard bench for wb_decoder     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_wb_decoder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  adr, dat_w;
  logic         we, cyc, stb;
  logic [3:0]   sel;

  logic [31:0]  s_dat, b_dat;
  logic         s_ack, s_err, b_ack, b_err;
  logic [31:0]  m_adr, m_dat, b_madr, b_mdat;
  logic         m_we, b_mwe;
  logic [3:0]   m_sel, m_cyc, m_stb, b_msel, b_mcyc, b_mstb;
  logic [7:0]   err_cnt, b_err_cnt;

  logic [127:0] m_dat_in;
  logic [3:0]   m_ack_in, m_err_in;
  logic [3:0]   auto_ack, force_ack, force_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_err;
    logic [31:0] dat;
  } exp_t;
  exp_t       sbq[$];
  exp_t       e;
  logic [7:0] exp_cnt = 8'h00;
  bit         cnt_chk = 1'b0;

  typedef struct {
    logic [31:0] adr;
    bit          we;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [3:0]  oh;
    bit          is_err;
    logic [31:0] dat;
    int          lat;
  } vec_t;
  vec_t vec[7];

  always #5 clk = ~clk;

  // Slave i returns C0DE_i<adr[11:0]>; auto_ack gives zero-wait slaves.
  for (genvar i = 0; i < 4; i++) begin : g_slv
    assign m_dat_in[i*32 +: 32] = 32'hC0DE_0000 | (32'(i) << 12) | {20'h0, m_adr[11:0]};
  end
  assign m_ack_in = (auto_ack & m_stb) | force_ack;
  assign m_err_in = force_err;

  wb_decoder #(.TIMEOUT(8), .UNMAPPED_ERR(1'b1)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_dat_o(s_dat),
    .wbs_we_i(we), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_sel_i(sel),
    .wbs_ack_o(s_ack), .wbs_err_o(s_err),
    .wbm_adr_o(m_adr), .wbm_dat_o(m_dat), .wbm_we_o(m_we), .wbm_sel_o(m_sel),
    .wbm_cyc_o(m_cyc), .wbm_stb_o(m_stb),
    .wbm_dat_i(m_dat_in), .wbm_ack_i(m_ack_in), .wbm_err_i(m_err_in),
    .err_cnt_o(err_cnt)
  );

  wb_decoder #(.TIMEOUT(8), .UNMAPPED_ERR(1'b0)) dut_b (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_dat_o(b_dat),
    .wbs_we_i(we), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_sel_i(sel),
    .wbs_ack_o(b_ack), .wbs_err_o(b_err),
    .wbm_adr_o(b_madr), .wbm_dat_o(b_mdat), .wbm_we_o(b_mwe), .wbm_sel_o(b_msel),
    .wbm_cyc_o(b_mcyc), .wbm_stb_o(b_mstb),
    .wbm_dat_i(m_dat_in), .wbm_ack_i(m_ack_in), .wbm_err_i(m_err_in),
    .err_cnt_o(b_err_cnt)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_req(input logic [31:0] a, input bit w, input logic [31:0] d, input logic [3:0] s);
    adr = a; we = w; dat_w = d; sel = s; cyc = 1'b1; stb = 1'b1;
  endtask

  task automatic wait_term(inout int lat);
    while (!(s_ack || s_err) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("term_seen", 128'(s_ack || s_err), 128'(1));
    cyc = 1'b0; stb = 1'b0;
  endtask

  // Scoreboard: every termination must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (cnt_chk) begin
      check("err_cnt", 128'(err_cnt), 128'(exp_cnt));
      cnt_chk = 1'b0;
    end
    if (rst_n && (s_ack || s_err)) begin
      if (sbq.size() == 0) begin
        check("spurious_term", 128'({s_ack, s_err}), 128'(0));
      end else begin
        e = sbq.pop_front();
        check("term_kind", 128'({s_ack, s_err}), e.is_err ? 128'(2'b01) : 128'(2'b10));
        check("rdata", 128'(s_dat), 128'(e.dat));
        check("resp_slave_idle", 128'({m_cyc, m_stb}), 128'(0));
        if (e.is_err && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        cnt_chk = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int lat;
    vec[0] = '{32'h1000_0004, 1'b0, 32'h0,         4'hF, 4'b0010, 1'b0, 32'hC0DE_1004, 2};
    vec[1] = '{32'h0000_0010, 1'b0, 32'h0,         4'hF, 4'b0001, 1'b0, 32'hC0DE_0010, 2};
    vec[2] = '{32'h3000_0ABC, 1'b0, 32'h0,         4'hC, 4'b1000, 1'b0, 32'hC0DE_3ABC, 2};
    vec[3] = '{32'h2000_0008, 1'b1, 32'h1234_5678, 4'h3, 4'b0100, 1'b0, 32'hC0DE_3ABC, 2};
    vec[4] = '{32'hF000_0000, 1'b0, 32'h0,         4'hF, 4'b0000, 1'b1, 32'hC0DE_3ABC, 1};
    vec[5] = '{32'h4000_0100, 1'b1, 32'hCAFE_F00D, 4'h1, 4'b0000, 1'b1, 32'hC0DE_3ABC, 1};
    vec[6] = '{32'h2000_0FF0, 1'b0, 32'h0,         4'hF, 4'b0100, 1'b0, 32'hC0DE_2FF0, 2};

    rst_n = 1'b0; adr = '0; dat_w = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0; sel = '0;
    auto_ack = 4'hF; force_ack = '0; force_err = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {s_dat, s_ack, s_err, m_adr, m_dat, m_we, m_sel, m_cyc, m_stb, err_cnt}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      sbq.push_back('{vec[v].is_err, vec[v].dat});
      start_req(vec[v].adr, vec[v].we, vec[v].wdat, vec[v].sel);
      @(negedge clk);
      lat = 1;
      check($sformatf("v%0d_onehot", v), 128'({m_cyc, m_stb}), 128'({vec[v].oh, vec[v].oh}));
      check($sformatf("v%0d_latched", v), 128'({m_adr, m_we, m_dat, m_sel}),
            128'({vec[v].adr, vec[v].we, vec[v].wdat, vec[v].sel}));
      wait_term(lat);
      check($sformatf("v%0d_latency", v), 128'(lat), 128'(vec[v].lat));
      @(negedge clk);
    end

    // Terminations while idle are ignored.
    force_ack = 4'hF; force_err = 4'hF;
    repeat (3) @(negedge clk);
    check("idle_no_term", 128'({s_ack, s_err, m_cyc}), 128'(0));
    force_ack = '0; force_err = '0;
    @(negedge clk);

    // Unmapped with black-hole ack on the second instance.
    sbq.push_back('{1'b1, 32'hC0DE_2FF0});
    start_req(32'hF000_0000, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    check("b_unmapped_ack", 128'({b_ack, b_err, b_dat}), 128'({1'b1, 1'b0, 32'hDEAD_BEEF}));
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);

    // Slave 2 never answers: err TIMEOUT+1 cycles after ACTIVE entry.
    auto_ack[2] = 1'b0;
    sbq.push_back('{1'b1, 32'hC0DE_2FF0});
    start_req(32'h2000_0040, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    check("timeout_stb", 128'(m_stb), 128'(4'b0100));
    lat = 0;
    wait_term(lat);
    check("timeout_latency", 128'(lat), 128'(9));
    @(negedge clk);

    // Ack arriving in the expiry cycle wins over the watchdog.
    sbq.push_back('{1'b0, 32'hC0DE_2040});
    start_req(32'h2000_0040, 1'b0, 32'h0, 4'hF);
    repeat (9) @(negedge clk);
    force_ack[2] = 1'b1;
    lat = 0;
    wait_term(lat);
    check("expiry_ack_latency", 128'(lat), 128'(1));
    force_ack = '0;
    @(negedge clk);

    // Simultaneous ack and err: err wins.
    auto_ack[3] = 1'b0;
    sbq.push_back('{1'b1, 32'hC0DE_2040});
    start_req(32'h3000_0000, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    force_ack[3] = 1'b1; force_err[3] = 1'b1;
    lat = 0;
    wait_term(lat);
    check("ack_err_latency", 128'(lat), 128'(1));
    force_ack = '0; force_err = '0;
    @(negedge clk);

    // Master abort after three wait cycles.
    auto_ack[1] = 1'b0;
    start_req(32'h1000_0000, 1'b0, 32'h0, 4'hF);
    repeat (3) @(negedge clk);
    check("abort_active", 128'(m_stb), 128'(4'b0010));
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("abort_drop", 128'({m_cyc, m_stb, s_ack, s_err}), 128'(0));
    repeat (2) @(negedge clk);
    check("abort_err_cnt", 128'(err_cnt), 128'(exp_cnt));
    auto_ack = 4'hF;

    // Saturate the error counter.
    for (int n = 0; n < 300; n++) begin
      sbq.push_back('{1'b1, 32'hC0DE_2040});
      start_req(32'hF000_0000, 1'b0, 32'h0, 4'hF);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    check("err_cnt_sat", 128'(err_cnt), 128'(8'hFF));

    // Asynchronous reset while ACTIVE, then a clean transfer.
    auto_ack[1] = 1'b0;
    start_req(32'h1000_0008, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    check("pre_reset_stb", 128'(m_stb), 128'(4'b0010));
    #2 rst_n = 1'b0;
    #1;
    check("reset_async",
          {s_dat, s_ack, s_err, m_adr, m_dat, m_we, m_sel, m_cyc, m_stb, err_cnt}, '0);
    cyc = 1'b0; stb = 1'b0;
    sbq.delete();
    exp_cnt = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    auto_ack = 4'hF;
    @(negedge clk);
    sbq.push_back('{1'b0, 32'hC0DE_1008});
    start_req(32'h1000_0008, 1'b0, 32'h0, 4'hF);
    lat = 0;
    wait_term(lat);
    check("post_reset_latency", 128'(lat), 128'(2));
    repeat (2) @(negedge clk);
    check("sb_drained", 128'(sbq.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
